fpdiv_rndpack: RTL and testbench
================================

# fpdiv_rndpack

Post-divide normalize/round/pack stage for the double-precision divide path. Captures sign, tentative exponent and special-case class when the mantissa divider is loaded. When the divider's one-cycle `done` pulse arrives, it normalizes the fixed-point quotient, rounds to nearest-even using the remainder as sticky, and packs an IEEE-754 binary64 result. The result is presented on a valid/ready output to the FPU result mux.

## Interface
- QW, default 112: divider quotient/remainder width; must be >= 58.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld  in  1  start of operation; asserted in the same cycle the divider's `ld` is asserted.
- sgn  in  1  result sign (sa ^ sb), captured on `ld`.
- xo  in  13  signed tentative biased exponent (ea - eb + 1023), captured on `ld`.
- spec  in  2  special class, captured on `ld`: 00 = normal, 01 = zero, 10 = infinity, 11 = NaN.
- div_done  in  1  divider completion pulse (one cycle).
- div_q  in  QW  divider quotient; fixed point, bit QW-2 has weight 1.0.
- div_r  in  QW  divider remainder; nonzero means inexact.
- o  out  64  packed result.
- o_valid  out  1  result valid.
- o_ready  in  1  consumer accepts `o` in a cycle where `o_valid` is also high.
- busy  out  1  high in any state except IDLE.
- ovf, unf, inex  out  1 each  exception flags; valid with `o_valid`.

## Operation
- States:
  - IDLE: `ld` -> WAIT.
  - WAIT: `div_done` -> NORM.
  - NORM: unconditional -> RND.
  - RND: unconditional -> HOLD.
  - HOLD: `o_valid`=1; `o_ready` -> IDLE.
- Quotient capture: `div_q`, and `rz` = (`div_r` != 0), are registered on the edge where `div_done`=1 in WAIT.
- NORM (normalize):
  - If q[QW-2]=1: nq = q, e = xo.
  - Else: nq = q<<1, e = xo - 1.
  - The quotient lies in [0.5, 2), so at most one shift occurs; q[QW-1] is always 0.
  - nq, e and rz are registered.
- RND (round):
  - frac = nq[QW-3:QW-54].
  - G = nq[QW-55].
  - S = |nq[QW-56:0] | rz.
  - Round up when G & (S | frac[0]).
  - Fraction carry-out: frac becomes 0 and e increments by 1.
- Exponent checks, applied after rounding:
  - e >= 2047: result is {sgn, 0x7FF, 52'b0}; ovf=1, inex=1.
  - e <= 0: flush to {sgn, 63'b0}; unf=1, inex=1. No subnormals are produced.
  - Otherwise: o = {sgn, e[10:0], frac}; inex = G|S.
- Special classes override the arithmetic result; all flags are 0:
  - 01 (zero): {sgn, 63'b0}.
  - 10 (infinity): {sgn, 0x7FF, 52'b0}.
  - 11 (NaN): 0x7FF8000000000000, sign forced to 0.
  - Special results use the same state path and latency; the divider still runs to completion.
- Boundary rules:
  - `ld` in any state aborts the current operation and enters WAIT with fresh side info; `o_valid` drops the next cycle.
  - `ld` in the same cycle as an accept (`o_valid` & `o_ready`): the accept completes, then the state is WAIT.
  - `ld` and `div_done` in the same cycle: `ld` wins, and that `div_done` is ignored.
  - `div_done` outside WAIT is ignored.
  - `rst` has priority over everything, including in mid-operation.

## Timing
- Reset values:
  - State IDLE; busy=0; o_valid=0.
  - o=0; ovf=0; unf=0; inex=0.
- Latency: if `div_done` is high in cycle T, `o_valid` rises in cycle T+3 (edges T, T+1 and T+2 register capture, normalize and round/pack respectively).
- `o` and the flags are registered and change only on the RND->HOLD edge.
- `o`, the flags and `o_valid` hold stable while `o_valid` & !`o_ready`.
- `o_valid` falls the cycle after an accept.
- Throughput: one result per divide. The block never asserts backpressure toward the divider; the sequencer must not issue `ld` while busy unless it intends to abort.

## Test plan
- 1.0/1.0:
  - Stimulus: ld with xo=1023, spec=00, sgn=0; div_done with q = 1<<(QW-2), r=0.
  - Required: o=0x3FF0000000000000, flags 0, o_valid exactly 3 cycles after div_done.
- Normalize shift:
  - Stimulus: q = 1<<(QW-3), xo=1023, sgn=1.
  - Required: o=0xBFE0000000000000.
- Round-to-nearest-even:
  - Stimulus: q = hidden | G bit, frac=0, r=0.
    - Required: frac unchanged, inex=1.
  - Stimulus: same with frac lsb=1.
    - Required: frac=2.
  - Stimulus: frac all ones, G=1.
    - Required: frac=0, exponent +1.
- Overflow/underflow:
  - Stimulus: xo=2047, q = 1<<(QW-2).
    - Required: o=0x7FF0000000000000, ovf=1, inex=1.
  - Stimulus: xo=1, q = 1<<(QW-3).
    - Required: o=0, unf=1.
- Specials: spec=11 -> o=0x7FF8000000000000; spec=01 with sgn=1 -> o=0x8000000000000000; flags 0 in both cases.
- Handshake/abort:
  - Stimulus: hold o_ready=0 for 5 cycles.
    - Required: o stable, then one accept.
  - Stimulus: ld in WAIT, or rst in NORM.
    - Required: no stale result; after rst, idle with o_valid=0.

Source files
------------

// File: rtl/fpdiv_rndpack.sv
// Post-divide normalize / round-to-nearest-even / pack stage producing an IEEE-754 binary64
// result on a valid/ready port.
module fpdiv_rndpack #(
    parameter int unsigned QW = 112
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic          sgn,
    input  logic [12:0]   xo,
    input  logic [1:0]    spec,
    input  logic          div_done,
    input  logic [QW-1:0] div_q,
    input  logic [QW-1:0] div_r,
    output logic [63:0]   o,
    output logic          o_valid,
    input  logic          o_ready,
    output logic          busy,
    output logic          ovf,
    output logic          unf,
    output logic          inex
);

    typedef enum logic [2:0] {StIdle, StWait, StNorm, StRnd, StHold} state_e;

    localparam logic [1:0] SpecZero = 2'b01;
    localparam logic [1:0] SpecInf  = 2'b10;
    localparam logic [1:0] SpecNan  = 2'b11;

    state_e             r_state, w_state_nxt;
    logic               r_sgn;
    logic signed [12:0] r_xo;
    logic [1:0]         r_spec;
    logic [QW-1:0]      r_q;
    logic               r_rz;
    logic [QW-3:0]      r_nq;
    logic signed [13:0] r_e;

    logic [QW-3:0]      w_norm_nq;
    logic signed [13:0] w_norm_e;
    logic [51:0]        w_frac;
    logic               w_g, w_s, w_up;
    logic [52:0]        w_frac_sum;
    logic signed [13:0] w_e_rnd;
    logic [63:0]        w_o;
    logic               w_ovf, w_unf, w_inex;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  w_state_nxt = StIdle;
            StWait:  if (div_done) w_state_nxt = StNorm;
            StNorm:  w_state_nxt = StRnd;
            StRnd:   w_state_nxt = StHold;
            StHold:  if (o_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        // A new load aborts whatever is in flight, even a completing accept.
        if (ld) w_state_nxt = StWait;
    end

    // Quotient is in [0.5, 2): either the 1.0 bit or the 0.5 bit leads.
    always_comb begin
        if (r_q[QW-1] | r_q[QW-2]) begin
            w_norm_nq = r_q[QW-3:0];
            w_norm_e  = {r_xo[12], r_xo};
        end else begin
            w_norm_nq = {r_q[QW-4:0], 1'b0};
            w_norm_e  = {r_xo[12], r_xo} - 14'sd1;
        end
    end

    always_comb begin
        w_frac     = r_nq[QW-3 -: 52];
        w_g        = r_nq[QW-55];
        w_s        = (|r_nq[QW-56:0]) | r_rz;
        w_up       = w_g & (w_s | w_frac[0]);
        w_frac_sum = {1'b0, w_frac} + 53'(w_up);
        w_e_rnd    = r_e + $signed({13'b0, w_frac_sum[52]});

        w_o    = {r_sgn, w_e_rnd[10:0], w_frac_sum[51:0]};
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        w_inex = w_g | w_s;
        if (w_e_rnd >= 14'sd2047) begin
            w_o    = {r_sgn, 11'h7ff, 52'b0};
            w_ovf  = 1'b1;
            w_inex = 1'b1;
        end else if (w_e_rnd <= 14'sd0) begin
            w_o    = {r_sgn, 63'b0};
            w_unf  = 1'b1;
            w_inex = 1'b1;
        end

        if (r_spec != 2'b00) begin
            w_ovf  = 1'b0;
            w_unf  = 1'b0;
            w_inex = 1'b0;
            case (r_spec)
                SpecZero: w_o = {r_sgn, 63'b0};
                SpecInf:  w_o = {r_sgn, 11'h7ff, 52'b0};
                SpecNan:  w_o = 64'h7ff8_0000_0000_0000;
                default:  w_o = {r_sgn, 63'b0};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_sgn   <= 1'b0;
            r_xo    <= '0;
            r_spec  <= 2'b00;
            r_q     <= '0;
            r_rz    <= 1'b0;
            r_nq    <= '0;
            r_e     <= '0;
            o       <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            inex    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (ld) begin
                r_sgn  <= sgn;
                r_xo   <= xo;
                r_spec <= spec;
            end
            if (r_state == StWait && div_done && !ld) begin
                r_q  <= div_q;
                r_rz <= |div_r;
            end
            if (r_state == StNorm) begin
                r_nq <= w_norm_nq;
                r_e  <= w_norm_e;
            end
            if (r_state == StRnd) begin
                o    <= w_o;
                ovf  <= w_ovf;
                unf  <= w_unf;
                inex <= w_inex;
            end
        end
    end

    assign o_valid = (r_state == StHold);
    assign busy    = (r_state != StIdle);

endmodule

// File: tb/tb_fpdiv_rndpack.sv
// Directed bench for fpdiv_rndpack: hand-computed binary64 results, latency, handshake and
// abort behaviour.
module tb_fpdiv_rndpack;

    localparam int unsigned QW = 112;

    logic          clk = 1'b0;
    logic          rst, ld, sgn, div_done, o_ready;
    logic [12:0]   xo;
    logic [1:0]    spec;
    logic [QW-1:0] div_q, div_r;
    logic [63:0]   o;
    logic          o_valid, busy, ovf, unf, inex;

    int total = 0;
    int bad   = 0;

    logic [QW-1:0] q;

    fpdiv_rndpack #(.QW(QW)) dut (
        .clk(clk), .rst(rst), .ld(ld), .sgn(sgn), .xo(xo), .spec(spec),
        .div_done(div_done), .div_q(div_q), .div_r(div_r),
        .o(o), .o_valid(o_valid), .o_ready(o_ready), .busy(busy),
        .ovf(ovf), .unf(unf), .inex(inex)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic s, input logic [12:0] x, input logic [1:0] sp);
        ld = 1'b1; sgn = s; xo = x; spec = sp;
        step();
        ld = 1'b0;
    endtask

    // Pulse div_done, check 3-cycle latency, hold with o_ready low, then accept.
    task automatic finish_op(input logic [QW-1:0] qq, input logic [QW-1:0] rr,
                             input logic [63:0] exp_o, input logic [2:0] exp_f,
                             input int hold, input string tag);
        div_done = 1'b1; div_q = qq; div_r = rr;
        step();
        div_done = 1'b0; div_q = '0; div_r = '0;
        chk({tag, ".lat1"}, 64'(o_valid), 64'd0);
        step();
        chk({tag, ".lat2"}, 64'(o_valid), 64'd0);
        step();
        chk({tag, ".valid"}, 64'(o_valid), 64'd1);
        chk({tag, ".o"}, o, exp_o);
        chk({tag, ".flags"}, 64'({ovf, unf, inex}), 64'(exp_f));
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, ".hold_v"}, 64'(o_valid), 64'd1);
            chk({tag, ".hold_o"}, o, exp_o);
        end
        o_ready = 1'b1;
        step();
        o_ready = 1'b0;
        chk({tag, ".drop"}, 64'(o_valid), 64'd0);
        chk({tag, ".idle"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input logic s, input logic [12:0] x, input logic [1:0] sp,
                          input logic [QW-1:0] qq, input logic [QW-1:0] rr,
                          input logic [63:0] exp_o, input logic [2:0] exp_f, input string tag);
        start_op(s, x, sp);
        step();
        finish_op(qq, rr, exp_o, exp_f, 0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ld = 1'b0; sgn = 1'b0; xo = '0; spec = 2'b00;
        div_done = 1'b0; div_q = '0; div_r = '0; o_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst.o", o, 64'd0);
        chk("rst.valid", 64'(o_valid), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.flags", 64'({ovf, unf, inex}), 64'd0);

        // div_done while idle is ignored
        div_done = 1'b1; div_q = '0; div_q[QW-2] = 1'b1;
        step();
        div_done = 1'b0;
        step(); step(); step();
        chk("idle_done.busy", 64'(busy), 64'd0);
        chk("idle_done.valid", 64'(o_valid), 64'd0);

        q = '0; q[QW-2] = 1'b1;
        run_op(1'b0, 13'd1023, 2'b00, q, '0, 64'h3FF0_0000_0000_0000, 3'b000, "one");

        q = '0; q[QW-3] = 1'b1;
        run_op(1'b1, 13'd1023, 2'b00, q, '0, 64'hBFE0_0000_0000_0000, 3'b000, "nshift");

        q = '0; q[QW-2] = 1'b1; q[QW-55] = 1'b1;
        run_op(1'b0, 13'd1023, 2'b00, q, '0, 64'h3FF0_0000_0000_0000, 3'b001, "tie_even");

        q = '0; q[QW-2] = 1'b1; q[QW-54] = 1'b1; q[QW-55] = 1'b1;
        run_op(1'b0, 13'd1023, 2'b00, q, '0, 64'h3FF0_0000_0000_0002, 3'b001, "tie_odd");

        q = '0; q[QW-2] = 1'b1; q[QW-55] = 1'b1;
        run_op(1'b0, 13'd1023, 2'b00, q, 112'd5, 64'h3FF0_0000_0000_0001, 3'b001, "rem_sticky");

        q = '0; q[QW-2] = 1'b1; q[QW-3 -: 52] = {52{1'b1}}; q[QW-55] = 1'b1;
        run_op(1'b0, 13'd1023, 2'b00, q, '0, 64'h4000_0000_0000_0000, 3'b001, "carry");

        q = '0; q[QW-2] = 1'b1;
        run_op(1'b0, 13'd2047, 2'b00, q, '0, 64'h7FF0_0000_0000_0000, 3'b101, "ovf");

        q = '0; q[QW-3] = 1'b1;
        run_op(1'b0, 13'd1, 2'b00, q, '0, 64'h0, 3'b011, "unf");

        q = '0; q[QW-2] = 1'b1;
        run_op(1'b1, 13'd1023, 2'b11, q, '0, 64'h7FF8_0000_0000_0000, 3'b000, "nan");
        run_op(1'b1, 13'd1023, 2'b01, q, '0, 64'h8000_0000_0000_0000, 3'b000, "zero");
        run_op(1'b0, 13'd1023, 2'b10, q, 112'd1, 64'h7FF0_0000_0000_0000, 3'b000, "inf");

        // Backpressure: result held for 5 cycles then accepted once
        start_op(1'b0, 13'd1023, 2'b00);
        step();
        finish_op(q, '0, 64'h3FF0_0000_0000_0000, 3'b000, 5, "hold");

        // ld in WAIT replaces side info
        start_op(1'b0, 13'd1000, 2'b11);
        step();
        start_op(1'b1, 13'd1022, 2'b00);
        finish_op(q, '0, 64'hBFE0_0000_0000_0000, 3'b000, 0, "abort_wait");

        // ld together with div_done: done is ignored, fresh side info used
        start_op(1'b0, 13'd1023, 2'b00);
        ld = 1'b1; sgn = 1'b0; xo = 13'd1024; spec = 2'b00;
        div_done = 1'b1; div_q = '0; div_q[QW-3] = 1'b1;
        step();
        ld = 1'b0; div_done = 1'b0;
        step(); step(); step();
        chk("ld_done.valid", 64'(o_valid), 64'd0);
        chk("ld_done.busy", 64'(busy), 64'd1);
        finish_op(q, '0, 64'h4000_0000_0000_0000, 3'b000, 0, "ld_done");

        // ld in HOLD together with accept: goes to WAIT, valid drops
        start_op(1'b0, 13'd1023, 2'b00);
        div_done = 1'b1; div_q = q;
        step();
        div_done = 1'b0;
        step(); step();
        chk("ld_acc.valid", 64'(o_valid), 64'd1);
        o_ready = 1'b1; ld = 1'b1; sgn = 1'b1; xo = 13'd1023; spec = 2'b00;
        step();
        o_ready = 1'b0; ld = 1'b0;
        chk("ld_acc.drop", 64'(o_valid), 64'd0);
        chk("ld_acc.busy", 64'(busy), 64'd1);
        finish_op(q, '0, 64'hBFF0_0000_0000_0000, 3'b000, 0, "ld_acc");

        // rst in NORM: no stale result appears
        start_op(1'b0, 13'd1023, 2'b00);
        div_done = 1'b1; div_q = q;
        step();
        div_done = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_norm.valid", 64'(o_valid), 64'd0);
        chk("rst_norm.busy", 64'(busy), 64'd0);
        chk("rst_norm.o", o, 64'd0);
        step(); step(); step();
        chk("rst_norm.late", 64'(o_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
